noc_vc_input_buffer: RTL and testbench
======================================

Name: noc_vc_input_buffer

Overview:
- Next-generation per-port NoC input buffer.
- Splits an incoming flit stream into VCS independent virtual-channel FIFOs, each of DEPTH entries.
- Generalises the previous input FIFO in four ways:
  - flit width is a parameter;
  - flit bus is either shared or per-VC, chosen by a parameter;
  - flow control is either valid/ready or credit-based, chosen by a parameter;
  - per-VC occupancy and a sticky protocol-error flag are exported.
- Sits between a router input port and the VC allocator / switch.

Parameters:
- FLIT_W, 64, flit payload width in bits.
- VCS, 4, number of virtual channels (1..16).
- DEPTH, 8, entries per VC; must be a power of two, ≥2.
- THRESHOLD, DEPTH-2, occupancy at which o_vc_ready drops.
- PER_VC_FLIT, 0:
  - 0 = one shared FLIT_W input bus;
  - 1 = VCS separate lanes, lane v in bits [v*FLIT_W +: FLIT_W].
- CREDIT_MODE, 0:
  - 0 = valid/ready;
  - 1 = credit-based, with credit return on o_credit.
- CW, $clog2(DEPTH+1), width of each count field (derived; do not override).

Ports:
- noc_clk  in  1  clock; all logic is rising-edge.
- noc_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous flush of all VCs.
- i_valid  in  VCS  per-VC write request.
- i_flit  in  (PER_VC_FLIT?VCS:1)*FLIT_W  input flit(s).
- o_ready  out  VCS  per-VC write ready; equals !full[v].
- o_vc_ready  out  VCS  per-VC ready for a new packet; equals count[v] < THRESHOLD.
- o_credit  out  VCS  registered one-cycle credit-return pulse; constant 0 when CREDIT_MODE=0.
- o_valid  out  VCS  per-VC head flit valid; equals count[v] != 0.
- o_flit  out  VCS*FLIT_W  per-VC head flit, first-word-fall-through.
- i_ready  in  VCS  downstream pop for each VC.
- o_count  out  VCS*CW  per-VC occupancy.
- o_error  out  1  sticky protocol-error flag.

Behaviour:
- Reset (noc_rst_n=0), asynchronous:
  - all pointers and counts go to 0;
  - o_credit = 0 and o_error = 0;
  - o_valid = 0, o_ready = all 1s, o_vc_ready = all 1s, o_count = 0;
  - o_flit contents are don't-care.
  - Reset mid-transfer discards all stored flits and emits no credits.
- Storage and counting:
  - Each VC is a circular buffer with rd/wr pointers of $clog2(DEPTH) bits; pointers wrap naturally (DEPTH is a power of two).
  - count[v] is a registered CW-bit counter: +1 on push, -1 on pop, unchanged when both or neither occur.
- Push condition:
  - CREDIT_MODE=0: push[v] = i_valid[v] & o_ready[v].
  - CREDIT_MODE=1: push[v] = i_valid[v] & (!full[v] | pop[v]).
  - When CREDIT_MODE=1 and i_valid[v] & full[v] & !pop[v]: the flit is dropped, o_error is set, and state is unchanged.
- Pop condition: pop[v] = o_valid[v] & i_ready[v]. i_ready while empty has no effect.
- Full with simultaneous events:
  - CREDIT_MODE=0: o_ready stays 0 while full. There is no same-cycle read-to-write pass-through, so a push on a full VC is impossible.
  - CREDIT_MODE=1: push and pop in the same cycle on a full VC are both accepted; count stays DEPTH.
- Empty with simultaneous events:
  - Push and pop in the same cycle on an empty VC is impossible, because o_valid=0.
  - The written flit appears on o_flit with o_valid=1 on the cycle after the push edge (latency 1). There is no combinational bypass.
- Shared-bus mode (PER_VC_FLIT=0):
  - At most one i_valid bit may be high in a cycle.
  - If more than one is high, only the lowest-indexed VC is considered for the push, the other bits are ignored, and o_error is set.
- Per-VC lane mode (PER_VC_FLIT=1): all VCs may push in the same cycle.
- Credits:
  - o_credit[v] is a registered pulse on the cycle after each pop[v]. There is exactly one pulse per popped flit.
  - Upstream initialises its credit counter to DEPTH per VC.
- i_clear:
  - Takes priority over same-cycle push and pop.
  - Zeroes pointers, counts and o_error.
  - Emits no credits; upstream is flushed concurrently.
  - A pending o_credit from the previous cycle's pop is still output.
- o_error is cleared only by reset or i_clear.

Test Plan:
- VCS=4, DEPTH=8, mode 0, shared bus: push 8 flits 0x10..0x17 to VC2 -> o_ready[2]=0 after the 8th push, o_vc_ready[2]=0 from count 6, o_count[2]=8; pop all 8 -> data returns in order 0x10..0x17, o_valid[2]=0 after the last pop; other VCs untouched.
- Wrap-around: on VC0, alternate 3 pushes and 2 pops for 20 cycles -> FIFO order preserved across pointer wrap; o_count never exceeds 8.
- CREDIT_MODE=1, VC1 full, then i_valid[1] and i_ready[1] in the same cycle -> both accepted, o_count[1]=8, one o_credit[1] pulse next cycle, o_error=0. A second push with no pop -> flit dropped, o_error=1.
- PER_VC_FLIT=0, with i_valid=4'b0110 -> only VC1 written, o_error=1. With PER_VC_FLIT=1 and i_valid=4'b1111 carrying distinct lane data -> each VC holds its own lane's flit.
- i_clear asserted together with a push to VC3 holding 5 flits -> o_count[3]=0, o_valid[3]=0 next cycle, no o_credit pulse, o_error=0.
- Assert noc_rst_n low asynchronously, mid-cycle, with all VCs half full -> outputs take reset values immediately; after release, o_ready is all 1s and o_count is all 0.

Source files
------------

// File: rtl/noc_vc_input_buffer.sv
// Per-port NoC input buffer: VCS independent first-word-fall-through FIFOs with
// either valid/ready or credit-based flow control and a sticky protocol-error flag.
module noc_vc_input_buffer #(
    parameter int FLIT_W      = 64,
    parameter int VCS         = 4,
    parameter int DEPTH       = 8,
    parameter int THRESHOLD   = DEPTH - 2,
    parameter int PER_VC_FLIT = 0,
    parameter int CREDIT_MODE = 0,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic                                      noc_clk,
    input  logic                                      noc_rst_n,
    input  logic                                      i_clear,
    input  logic [VCS-1:0]                            i_valid,
    input  logic [(PER_VC_FLIT ? VCS : 1)*FLIT_W-1:0] i_flit,
    output logic [VCS-1:0]                            o_ready,
    output logic [VCS-1:0]                            o_vc_ready,
    output logic [VCS-1:0]                            o_credit,
    output logic [VCS-1:0]                            o_valid,
    output logic [VCS*FLIT_W-1:0]                     o_flit,
    input  logic [VCS-1:0]                            i_ready,
    output logic [VCS*CW-1:0]                         o_count,
    output logic                                      o_error
);

    localparam int PW = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem [VCS][DEPTH];
    logic [PW-1:0]     rd_ptr [VCS];
    logic [PW-1:0]     wr_ptr [VCS];
    logic [CW-1:0]     count  [VCS];
    logic [FLIT_W-1:0] flit_in [VCS];

    logic [VCS-1:0] full;
    logic [VCS-1:0] valid_eff;
    logic [VCS-1:0] push;
    logic [VCS-1:0] pop;
    logic [VCS-1:0] drop;
    logic           multi;

    for (genvar g = 0; g < VCS; g++) begin : g_lane
        if (PER_VC_FLIT != 0) begin : g_per_vc
            assign flit_in[g] = i_flit[g*FLIT_W +: FLIT_W];
        end else begin : g_shared
            assign flit_in[g] = i_flit[FLIT_W-1:0];
        end
    end

    // On the shared bus only the lowest requesting VC may write; extra requests flag an error.
    always_comb begin
        multi      = 1'b0;
        valid_eff  = i_valid;
        full       = '0;
        o_valid    = '0;
        o_ready    = '0;
        o_vc_ready = '0;
        pop        = '0;
        push       = '0;
        drop       = '0;
        o_count    = '0;
        o_flit     = '0;
        if (PER_VC_FLIT == 0) begin
            multi     = |(i_valid & (i_valid - VCS'(1)));
            valid_eff = i_valid & (~i_valid + VCS'(1));
        end
        for (int v = 0; v < VCS; v++) begin
            full[v]       = (count[v] == CW'(DEPTH));
            o_valid[v]    = (count[v] != '0);
            o_ready[v]    = !full[v];
            o_vc_ready[v] = (count[v] < CW'(THRESHOLD));
            pop[v]        = o_valid[v] & i_ready[v];
            if (CREDIT_MODE != 0) begin
                push[v] = valid_eff[v] & (!full[v] | pop[v]);
                drop[v] = valid_eff[v] & full[v] & !pop[v];
            end else begin
                push[v] = valid_eff[v] & !full[v];
            end
            o_count[v*CW +: CW]       = count[v];
            o_flit[v*FLIT_W +: FLIT_W] = mem[v][rd_ptr[v]];
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            for (int v = 0; v < VCS; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                count[v]  <= '0;
            end
            o_credit <= '0;
            o_error  <= 1'b0;
        end else if (i_clear) begin
            for (int v = 0; v < VCS; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                count[v]  <= '0;
            end
            o_credit <= '0;
            o_error  <= 1'b0;
        end else begin
            for (int v = 0; v < VCS; v++) begin
                if (push[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
                if (pop[v])  rd_ptr[v] <= rd_ptr[v] + PW'(1);
                if (push[v] && !pop[v])      count[v] <= count[v] + CW'(1);
                else if (pop[v] && !push[v]) count[v] <= count[v] - CW'(1);
            end
            o_credit <= (CREDIT_MODE != 0) ? pop : '0;
            if (multi || (|drop)) o_error <= 1'b1;
        end
    end

    // Storage has no reset; its contents are only visible once count says they are valid.
    always_ff @(posedge noc_clk) begin
        for (int v = 0; v < VCS; v++) begin
            if (noc_rst_n && !i_clear && push[v]) mem[v][wr_ptr[v]] <= flit_in[v];
        end
    end

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Directed bench: three buffer instances cover shared-bus valid/ready, shared-bus
// credit mode and per-VC lanes, checked against a vector table and short sequences.
module tb_noc_vc_input_buffer;

    localparam int W  = 16;
    localparam int V  = 4;
    localparam int D  = 8;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           a_clear = 1'b0, b_clear = 1'b0, c_clear = 1'b0;
    logic [V-1:0]   a_valid = '0, b_valid = '0, c_valid = '0;
    logic [V-1:0]   a_ready = '0, b_ready = '0, c_ready = '0;
    logic [W-1:0]   a_flit = '0, b_flit = '0;
    logic [V*W-1:0] c_flit = '0;
    logic [V-1:0]   a_oready, a_vcready, a_credit, a_ovalid;
    logic [V-1:0]   b_oready, b_vcready, b_credit, b_ovalid;
    logic [V-1:0]   c_oready, c_vcready, c_credit, c_ovalid;
    logic [V*W-1:0] a_oflit, b_oflit, c_oflit;
    logic [V*CW-1:0] a_count, b_count, c_count;
    logic           a_error, b_error, c_error;

    noc_vc_input_buffer #(.FLIT_W(W), .VCS(V), .DEPTH(D), .PER_VC_FLIT(0), .CREDIT_MODE(0)) u_a (
        .noc_clk(clk), .noc_rst_n(rst_n), .i_clear(a_clear), .i_valid(a_valid), .i_flit(a_flit),
        .o_ready(a_oready), .o_vc_ready(a_vcready), .o_credit(a_credit), .o_valid(a_ovalid),
        .o_flit(a_oflit), .i_ready(a_ready), .o_count(a_count), .o_error(a_error));

    noc_vc_input_buffer #(.FLIT_W(W), .VCS(V), .DEPTH(D), .PER_VC_FLIT(0), .CREDIT_MODE(1)) u_b (
        .noc_clk(clk), .noc_rst_n(rst_n), .i_clear(b_clear), .i_valid(b_valid), .i_flit(b_flit),
        .o_ready(b_oready), .o_vc_ready(b_vcready), .o_credit(b_credit), .o_valid(b_ovalid),
        .o_flit(b_oflit), .i_ready(b_ready), .o_count(b_count), .o_error(b_error));

    noc_vc_input_buffer #(.FLIT_W(W), .VCS(V), .DEPTH(D), .PER_VC_FLIT(1), .CREDIT_MODE(0)) u_c (
        .noc_clk(clk), .noc_rst_n(rst_n), .i_clear(c_clear), .i_valid(c_valid), .i_flit(c_flit),
        .o_ready(c_oready), .o_vc_ready(c_vcready), .o_credit(c_credit), .o_valid(c_ovalid),
        .o_flit(c_oflit), .i_ready(c_ready), .o_count(c_count), .o_error(c_error));

    typedef struct {
        logic [V-1:0]    valid;
        logic [W-1:0]    flit;
        logic [V-1:0]    ready;
        logic [V-1:0]    e_ready;
        logic [V-1:0]    e_vc_ready;
        logic [V-1:0]    e_valid;
        logic [V*CW-1:0] e_count;
        logic [W-1:0]    e_head2;
    } vec_t;

    vec_t vecs[16];
    int compared   = 0;
    int mismatched = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives one table row into instance A, clocks it, and compares the post-edge state.
    task automatic apply_stimulus(input vec_t t);
        a_valid = t.valid;
        a_flit  = t.flit;
        a_ready = t.ready;
        step;
        a_valid = '0;
        a_ready = '0;
        check_output("tbl_ready", a_oready, t.e_ready);
        check_output("tbl_vc_ready", a_vcready, t.e_vc_ready);
        check_output("tbl_valid", a_ovalid, t.e_valid);
        check_output("tbl_count", a_count, t.e_count);
        check_output("tbl_credit", a_credit, 4'h0);
        check_output("tbl_error", a_error, 1'b0);
        if (t.e_valid[2]) check_output("tbl_head2", a_oflit[47:32], t.e_head2);
    endtask

    logic [W-1:0] q[$];
    logic [W-1:0] next_val;
    int           credits;

    initial begin
        vecs[0]  = '{4'b0100, 16'h10, 4'b0000, 4'hF, 4'hF, 4'b0100, 16'h0100, 16'h10};
        vecs[1]  = '{4'b0100, 16'h11, 4'b0000, 4'hF, 4'hF, 4'b0100, 16'h0200, 16'h10};
        vecs[2]  = '{4'b0100, 16'h12, 4'b0000, 4'hF, 4'hF, 4'b0100, 16'h0300, 16'h10};
        vecs[3]  = '{4'b0100, 16'h13, 4'b0000, 4'hF, 4'hF, 4'b0100, 16'h0400, 16'h10};
        vecs[4]  = '{4'b0100, 16'h14, 4'b0000, 4'hF, 4'hF, 4'b0100, 16'h0500, 16'h10};
        vecs[5]  = '{4'b0100, 16'h15, 4'b0000, 4'hF, 4'hB, 4'b0100, 16'h0600, 16'h10};
        vecs[6]  = '{4'b0100, 16'h16, 4'b0000, 4'hF, 4'hB, 4'b0100, 16'h0700, 16'h10};
        vecs[7]  = '{4'b0100, 16'h17, 4'b0000, 4'hB, 4'hB, 4'b0100, 16'h0800, 16'h10};
        vecs[8]  = '{4'b0000, 16'h00, 4'b0100, 4'hF, 4'hB, 4'b0100, 16'h0700, 16'h11};
        vecs[9]  = '{4'b0000, 16'h00, 4'b0100, 4'hF, 4'hB, 4'b0100, 16'h0600, 16'h12};
        vecs[10] = '{4'b0000, 16'h00, 4'b0100, 4'hF, 4'hF, 4'b0100, 16'h0500, 16'h13};
        vecs[11] = '{4'b0000, 16'h00, 4'b0100, 4'hF, 4'hF, 4'b0100, 16'h0400, 16'h14};
        vecs[12] = '{4'b0000, 16'h00, 4'b0100, 4'hF, 4'hF, 4'b0100, 16'h0300, 16'h15};
        vecs[13] = '{4'b0000, 16'h00, 4'b0100, 4'hF, 4'hF, 4'b0100, 16'h0200, 16'h16};
        vecs[14] = '{4'b0000, 16'h00, 4'b0100, 4'hF, 4'hF, 4'b0100, 16'h0100, 16'h17};
        vecs[15] = '{4'b0000, 16'h00, 4'b0100, 4'hF, 4'hF, 4'b0000, 16'h0000, 16'h00};

        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", a_ovalid, 4'h0);
        check_output("rst_ready", a_oready, 4'hF);
        check_output("rst_vc_ready", a_vcready, 4'hF);
        check_output("rst_count", a_count, 16'h0);
        check_output("rst_credit", b_credit, 4'h0);
        check_output("rst_error", b_error, 1'b0);
        rst_n = 1'b1;
        step;

        for (int i = 0; i < 16; i++) apply_stimulus(vecs[i]);

        // Three pushes then two pops per group drive VC0 pointers past the wrap point.
        next_val = 16'h100;
        for (int c = 0; c < 20; c++) begin
            if (c % 5 < 3) begin
                check_output("wrap_ready", a_oready[0], 1'b1);
                a_valid = 4'b0001;
                a_flit  = next_val;
                q.push_back(next_val);
                next_val++;
            end else begin
                check_output("wrap_head", a_oflit[15:0], q[0]);
                void'(q.pop_front());
                a_ready = 4'b0001;
            end
            step;
            a_valid = '0;
            a_ready = '0;
            check_output("wrap_count", a_count[3:0], q.size());
        end
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            check_output("wrap_drain_head", a_oflit[15:0], q[0]);
            void'(q.pop_front());
            a_ready = 4'b0001;
            step;
            a_ready = '0;
        end
        check_output("wrap_empty", a_ovalid, 4'h0);

        a_valid = 4'b0110;
        a_flit  = 16'h00AB;
        step;
        a_valid = '0;
        check_output("shared_count", a_count, 16'h0010);
        check_output("shared_error", a_error, 1'b1);
        check_output("shared_head1", a_oflit[31:16], 16'h00AB);

        for (int k = 0; k < 8; k++) begin
            b_valid = 4'b0010;
            b_flit  = W'(16'h20 + k);
            step;
            check_output("cr_fill_credit", b_credit, 4'h0);
        end
        b_valid = '0;
        check_output("cr_full_count", b_count[7:4], 4'd8);
        check_output("cr_full_ready", b_oready[1], 1'b0);
        b_valid = 4'b0010;
        b_flit  = 16'h28;
        b_ready = 4'b0010;
        step;
        b_valid = '0;
        b_ready = '0;
        check_output("cr_pass_count", b_count[7:4], 4'd8);
        check_output("cr_pass_credit", b_credit, 4'b0010);
        check_output("cr_pass_error", b_error, 1'b0);
        check_output("cr_pass_head", b_oflit[31:16], 16'h21);
        step;
        check_output("cr_single_pulse", b_credit, 4'h0);
        b_valid = 4'b0010;
        b_flit  = 16'h29;
        step;
        b_valid = '0;
        check_output("cr_drop_error", b_error, 1'b1);
        check_output("cr_drop_count", b_count[7:4], 4'd8);
        credits = 0;
        for (int i = 0; i < 8; i++) begin
            check_output("cr_drain_head", b_oflit[31:16], W'(16'h21 + i));
            b_ready = 4'b0010;
            step;
            credits += int'(b_credit[1]);
        end
        b_ready = '0;
        step;
        check_output("cr_credit_total", credits, 8);
        check_output("cr_credit_idle", b_credit, 4'h0);
        check_output("cr_error_sticky", b_error, 1'b1);

        for (int k = 0; k < 5; k++) begin
            b_valid = 4'b1000;
            b_flit  = W'(16'h30 + k);
            step;
        end
        b_valid = '0;
        check_output("clr_pre_count", b_count[15:12], 4'd5);
        b_valid = 4'b1010;
        b_flit  = 16'h40;
        b_ready = 4'b1000;
        step;
        check_output("clr_multi_count", b_count, 16'h4010);
        check_output("clr_multi_credit", b_credit, 4'b1000);
        b_clear = 1'b1;
        b_valid = 4'b1000;
        b_flit  = 16'h50;
        step;
        b_clear = 1'b0;
        b_valid = '0;
        b_ready = '0;
        check_output("clr_count", b_count, 16'h0);
        check_output("clr_valid", b_ovalid, 4'h0);
        check_output("clr_credit", b_credit, 4'h0);
        check_output("clr_error", b_error, 1'b0);
        step;
        check_output("clr_after_credit", b_credit, 4'h0);

        c_valid = 4'hF;
        c_flit  = 64'h00D3_00C2_00B1_00A0;
        step;
        check_output("lane_flits", c_oflit, 64'h00D3_00C2_00B1_00A0);
        check_output("lane_count", c_count, 16'h1111);
        check_output("lane_error", c_error, 1'b0);
        c_flit = 64'h1111_2222_3333_4444;
        repeat (3) step;
        c_valid = '0;
        check_output("lane_half_count", c_count, 16'h4444);
        check_output("lane_head_kept", c_oflit, 64'h00D3_00C2_00B1_00A0);
        check_output("lane_credit", c_credit, 4'h0);

        // Reset lands between clock edges; outputs must react without waiting for one.
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_valid", c_ovalid, 4'h0);
        check_output("arst_ready", c_oready, 4'hF);
        check_output("arst_vc_ready", c_vcready, 4'hF);
        check_output("arst_count", c_count, 16'h0);
        check_output("arst_a_error", a_error, 1'b0);
        check_output("arst_a_count", a_count, 16'h0);
        #3;
        rst_n = 1'b1;
        step;
        check_output("post_rst_ready", c_oready, 4'hF);
        check_output("post_rst_count", c_count, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
